// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, oversampling constants and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: divides Clk by CLK_DIV into an oversample tick, restartable for phase alignment
module uart_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x oversampled UART receiver with parity/stop checking
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Rx_Busy
);
  rx_state_t state;
  logic rx_m, rx_s, tick, start_det, samp, par_err;
  logic [3:0] os, bit_idx;
  logic [DATA_BITS-1:0] shreg;
  assign start_det = state == IDLE && !rx_s && !BIST_Mode;
  // start bit is sampled at its midpoint, every later bit one full bit period on
  assign samp = tick && os == (state == START ? 4'(MID_SAMPLE - 1) : 4'(OVERSAMPLE - 1));
  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk(Clk),
    .Rst(Rst),
    .restart(start_det),
    .tick(tick)
  );
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      os <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par_err <= 1'b0;
      Rx_Data <= '0;
      Data_Rdy <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err <= 1'b0;
      Rx_Busy <= 1'b0;
    end else begin
      rx_m <= Rx;
      rx_s <= rx_m;
      Data_Rdy <= 1'b0;
      if (tick && state != IDLE && state != BREAK) os <= samp ? '0 : os + 1'b1;
      case (state)
        IDLE: if (start_det) begin
          state <= START;
          os <= '0;
          bit_idx <= '0;
          par_err <= 1'b0;
          Rx_Busy <= 1'b1;
        end
        START: if (samp) begin
          state <= rx_s ? IDLE : DATA;
          Rx_Busy <= !rx_s;
        end
        DATA: if (samp) begin
          shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 4'(DATA_BITS - 1)) state <= PARITY_EN != 0 ? PARITY : STOP;
        end
        PARITY: if (samp) begin
          par_err <= rx_s != calc_parity(9'(shreg), PARITY_ODD != 0);
          state <= STOP;
        end
        STOP: if (samp) begin
          Data_Rdy <= 1'b1;
          Rx_Data <= shreg;
          Parity_Err <= par_err;
          Frame_Err <= !rx_s;
          Rx_Busy <= !rx_s;
          state <= rx_s ? IDLE : BREAK;
        end
        BREAK: if (rx_s) begin
          state <= IDLE;
          Rx_Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: scoreboard bench for 8N1 and 8E1 receivers
module tb_uart_rx_deserializer;
  typedef struct {
    logic [7:0] d;
    logic pe;
    logic fe;
    int cyc;
  } exp_t;
  logic Clk = 0, Rst = 1, rx_a = 1, rx_b = 1, bist = 0;
  logic [7:0] data_a, data_b;
  logic rdy_a, rdy_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  uart_rx_deserializer #(.DATA_BITS(8), .CLK_DIV(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .Clk(Clk), .Rst(Rst), .Rx(rx_a), .BIST_Mode(bist), .Rx_Data(data_a), .Data_Rdy(rdy_a),
    .Parity_Err(pe_a), .Frame_Err(fe_a), .Rx_Busy(busy_a)
  );
  uart_rx_deserializer #(.DATA_BITS(8), .CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .Rx(rx_b), .BIST_Mode(bist), .Rx_Data(data_b), .Data_Rdy(rdy_b),
    .Parity_Err(pe_b), .Frame_Err(fe_b), .Rx_Busy(busy_b)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Data_Rdy appears 154 cycles after the start-bit drive for 8N1 and 170 for 8E1
  task automatic push(input int sel, input logic [7:0] d, input logic pe, input logic fe);
    if (sel == 0) qa.push_back('{d, pe, fe, cyc + 154});
    else qb.push_back('{d, pe, fe, cyc + 170});
  endtask
  task automatic drv(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask
  task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv(sel, bits[i]);
      repeat (16) @(negedge Clk);
    end
  endtask
  task automatic send(input int sel, input logic [15:0] bits, input int n);
    drive_bits(sel, bits, n);
    drv(sel, 1'b1);
  endtask
  always @(negedge Clk)
    if (rdy_a) begin
      if (qa.size() == 0) check("a_unexpected_rdy", 32'(data_a), 32'hdead);
      else begin
        ea = qa.pop_front();
        check("a_data", 32'(data_a), 32'(ea.d));
        check("a_perr", 32'(pe_a), 32'(ea.pe));
        check("a_ferr", 32'(fe_a), 32'(ea.fe));
        check("a_rdy_cycle", cyc, ea.cyc);
        check("a_busy_at_rdy", 32'(busy_a), 32'(ea.fe));
      end
    end
  always @(negedge Clk)
    if (rdy_b) begin
      if (qb.size() == 0) check("b_unexpected_rdy", 32'(data_b), 32'hdead);
      else begin
        eb = qb.pop_front();
        check("b_data", 32'(data_b), 32'(eb.d));
        check("b_perr", 32'(pe_b), 32'(eb.pe));
        check("b_ferr", 32'(fe_b), 32'(eb.fe));
        check("b_rdy_cycle", cyc, eb.cyc);
      end
    end
  initial begin
    repeat (3) @(negedge Clk);
    check("rst_outputs_a", {data_a, rdy_a, pe_a, fe_a, busy_a}, 0);
    check("rst_outputs_b", {data_b, rdy_b, pe_b, fe_b, busy_b}, 0);
    Rst = 0;
    repeat (5) @(negedge Clk);
    push(0, 8'hA5, 0, 0);
    send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (20) @(negedge Clk);
    push(1, 8'h03, 1, 0);
    send(1, {5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    push(1, 8'h07, 0, 0);
    send(1, {5'h1f, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge Clk);
    push(0, 8'h55, 0, 1);
    drive_bits(0, {4'h0, 3'b000, 8'h55, 1'b0}, 12);
    check("break_busy", 32'(busy_a), 1);
    rx_a = 1;
    repeat (5) @(negedge Clk);
    check("break_exit_busy", 32'(busy_a), 0);
    repeat (20) @(negedge Clk);
    rx_a = 0;
    repeat (4) @(negedge Clk);
    rx_a = 1;
    check("glitch_busy", 32'(busy_a), 1);
    repeat (20) @(negedge Clk);
    check("glitch_idle", 32'(busy_a), 0);
    drive_bits(0, {7'h7f, 8'h3C, 1'b0}, 5);
    rx_a = 1;
    repeat (8) @(negedge Clk);
    Rst = 1;
    #1;
    check("midframe_rst_a", {data_a, rdy_a, pe_a, fe_a, busy_a}, 0);
    repeat (2) @(negedge Clk);
    Rst = 0;
    repeat (20) @(negedge Clk);
    push(0, 8'hC3, 0, 0);
    send(0, {6'h3f, 1'b1, 8'hC3, 1'b0}, 10);
    repeat (20) @(negedge Clk);
    push(0, 8'h00, 0, 0);
    send(0, {6'h3f, 1'b1, 8'h00, 1'b0}, 10);
    push(0, 8'hFF, 0, 0);
    send(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10);
    push(0, 8'h81, 0, 0);
    send(0, {6'h3f, 1'b1, 8'h81, 1'b0}, 10);
    bist = 1;
    send(0, {6'h3f, 1'b1, 8'h42, 1'b0}, 10);
    bist = 0;
    repeat (40) @(negedge Clk);
    check("a_pending_frames", qa.size(), 0);
    check("b_pending_frames", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
